fetch_sequencer: RTL

- Drives the program counter (PC) interface: generates the increment and branch-enable pulses and supplies the branch offset.
- Consumes the PC value, issues instruction-memory reads at that address, and buffers returned instructions in a small FIFO toward decode.
- Accepts redirects from execute, flushes in-flight work and steers the PC.
- Sits between the PC register, instruction memory and decode in the single-cycle-derived core.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_sequencer_if.sv | 23 ++
 rtl/fetch_sequencer_queue.sv | 75 +++++++
 rtl/fetch_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch sequencer: FSM states, the queued
// fetch entry and the default datapath/queue sizes.
package fetch_pkg;

  localparam int FETCH_XLEN     = 32;
  localparam int FETCH_FQ_DEPTH = 2;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DRAIN
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response bus. The fetch sequencer is the master;
// the memory (or a bench model of it) is the slave.
interface fetch_imem_if #(
  parameter int XLEN = 32
);

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/fetch_sequencer_queue.sv
// Small circular FIFO of fetched instructions toward decode. Flush empties it
// and takes priority over a push or pop in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = FETCH_FQ_DEPTH,
  parameter type entry_t = fetch_entry_t,
  localparam int CNT_W   = $clog2(DEPTH + 1),
  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  entry_t           entry_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [CNT_W-1:0] count_o,
  output entry_t           head_o
);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign do_push = push_i & ~flush_i;
  assign do_pop  = pop_i & ~flush_i & (count_q != '0);

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count gates every read, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one outstanding imem read at a time, PC increment/branch
// pulses, redirect handling with flush/drain, and a fetch queue toward decode.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int XLEN     = FETCH_XLEN,
  parameter int FQ_DEPTH = FETCH_FQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_increment_en_o,
  output logic            pc_branch_en_o,
  output logic [XLEN-1:0] pc_branch_offset_o,
  fetch_imem_if.master    imem,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_offset_i,
  output logic            inst_valid_o,
  input  logic            inst_ready_i,
  output logic [XLEN-1:0] inst_data_o,
  output logic [XLEN-1:0] inst_pc_o
);

  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CNT_W-1:0] count;
  entry_t          head, entry_in;
  logic            can_req, req_valid, incr, branch, push, pop, flush;

  assign can_req  = (count < CNT_W'(FQ_DEPTH));
  assign entry_in = '{pc: req_pc_q, inst: imem.rsp_data};

  // A redirect wins over everything; a response arriving with it is dropped.
  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    req_valid = 1'b0;
    incr      = 1'b0;
    branch    = 1'b0;
    push      = 1'b0;
    flush     = 1'b0;
    if (redirect_valid_i) begin
      branch = 1'b1;
      flush  = 1'b1;
      case (state_q)
        WAIT, DRAIN: state_d = imem.rsp_valid ? REQ : DRAIN;
        default:     state_d = REQ;
      endcase
    end else begin
      case (state_q)
        REQ: begin
          req_valid = can_req;
          if (can_req && imem.req_ready) begin
            req_pc_d = pc_i;
            state_d  = WAIT;
          end
        end
        WAIT: if (imem.rsp_valid) begin
          push    = 1'b1;
          incr    = 1'b1;
          state_d = REQ;
        end
        DRAIN:   if (imem.rsp_valid) state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= REQ;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      req_pc_q <= req_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (entry_in),
    .pop_i   (pop),
    .flush_i (flush),
    .count_o (count),
    .head_o  (head)
  );

  // Combinational outputs are forced low while reset is held.
  assign imem.req_valid     = req_valid & ~rst;
  assign imem.req_addr      = rst ? '0 : pc_i;
  assign pc_increment_en_o  = incr & ~rst;
  assign pc_branch_en_o     = branch & ~rst;
  assign pc_branch_offset_o = rst ? '0 : redirect_offset_i;

  assign inst_valid_o = (count != '0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign inst_data_o  = inst_valid_o ? head.inst : '0;
  assign inst_pc_o    = inst_valid_o ? head.pc : '0;

endmodule
